// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_pkg
//  Purpose  : Shared types and decode helpers for the iterative RV32M/RV64M
//             multiply/divide unit (funct3 encoding, FSM states, signedness
//             and operation-class helpers).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  // M-extension funct3 encodings
  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // funct3[2] separates the divide group from the multiply group
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // Within the divide group, funct3[1] selects the remainder
  function automatic logic is_rem(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  // rs1 is signed for MUL/MULH/MULHSU and DIV/REM
  function automatic logic a_signed(input logic [2:0] f3);
    if (f3[2]) return ~f3[0];
    return (f3 != 3'b011);
  endfunction

  // rs2 is signed for MUL/MULH and DIV/REM
  function automatic logic b_signed(input logic [2:0] f3);
    if (f3[2]) return ~f3[0];
    return ~f3[1];
  endfunction

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_seq_if
//  Purpose  : Request/response handshake bundle between the core controller
//             (master) and the multiply/divide unit (slave).
//  Signals  : in_valid/in_ready  - operand handshake
//             funct3, op_a, op_b - operation select and operands
//             out_valid/out_ready- result handshake
//             result             - rd value
//  Revision : 1.0 - initial release
// ============================================================================
interface mdu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, funct3, op_a, op_b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, funct3, op_a, op_b, out_ready,
    output in_ready, out_valid, result
  );
endinterface : mdu_seq_if
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_iter
//  Purpose  : One-bit step of the iterative datapath, purely combinational.
//             Multiply: shift-add, multiplier in the low half of acc, partial
//             product accumulating in the high half, shifting right.
//             Divide: restoring step, dividend/quotient in the low half,
//             partial remainder in the high half, shifting left.
//  Ports    : is_div_i - select divide step (else multiply step)
//             acc_i    - current 2*XLEN accumulator
//             opnd_i   - multiplicand / divisor magnitude
//             acc_o    - accumulator after one step
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] sum_d;
  logic [XLEN:0] diff_d;

  always_comb begin
    // Carry out of the add becomes the new top bit after the right shift
    sum_d  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Remainder shifted left by one, pulling in the next dividend bit
    diff_d = acc_i[2*XLEN-1:XLEN-1] - {1'b0, opnd_i};

    if (!is_div_i) begin
      acc_o = {sum_d, acc_i[XLEN-1:1]};
    end else if (!diff_d[XLEN]) begin
      // Subtraction fits: keep it and shift in a quotient one
      acc_o = {diff_d[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    end else begin
      // Restore: plain shift with a quotient zero
      acc_o = {acc_i[2*XLEN-2:0], 1'b0};
    end
  end

endmodule : mdu_iter
`default_nettype wire

// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_seq
//  Purpose  : Iterative RV32M/RV64M multiply/divide unit. Operands are
//             reduced to magnitudes on accept, XLEN single-bit steps run in
//             CALC, FIXUP applies sign correction and the divide special
//             cases, DONE presents the result until the consumer takes it.
//  Ports    : clk     - clock, rising edge
//             reset_n - asynchronous active-low reset
//             flush   - synchronous abort, priority over accept/out_ready
//             bus     - mdu_seq_if slave (in/out handshakes, funct3,
//                       op_a, op_b, result)
//  Options  : MDU_FAST_SPECIAL_EN - divide by zero, signed overflow and
//             multiply with a zero operand complete IDLE -> DONE directly.
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  mdu_seq_if.slave     bus
);

  localparam int              CW      = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_END = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Special-case detection; the multiply zero-operand case only matters for
  // the early exit since the iterative result is already zero.
  function automatic logic is_special(input logic [2:0] f3,
                                      input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
    if (is_div(f3)) return (b == '0) || (a_signed(f3) && (a == MIN_NEG) && (b == '1));
    return (a == '0) || (b == '0);
  endfunction

  function automatic logic [XLEN-1:0] special_val(input logic [2:0] f3,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    if (!is_div(f3)) return '0;
    if (b == '0)     return is_rem(f3) ? a : '1;
    return is_rem(f3) ? '0 : a;
  endfunction

  // Registered state
  state_e              state_q;
  funct3_e             f3_q;
  logic [XLEN-1:0]     op_a_q;
  logic [XLEN-1:0]     op_b_q;
  logic                sa_q;
  logic                sb_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [CW-1:0]       cnt_q;
  logic [XLEN-1:0]     result_q;
  logic                out_valid_q;
  logic                in_ready_q;

  // Combinational next values
  logic                sa_in;
  logic                sb_in;
  logic [XLEN-1:0]     mag_a_in;
  logic [XLEN-1:0]     mag_b;
  logic [2*XLEN-1:0]   acc_d;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo;
  logic [XLEN-1:0]     rem;
  logic [XLEN-1:0]     result_d;

  assign sa_in    = a_signed(bus.funct3) & bus.op_a[XLEN-1];
  assign sb_in    = b_signed(bus.funct3) & bus.op_b[XLEN-1];
  assign mag_a_in = sa_in ? -bus.op_a : bus.op_a;
  // Divisor / multiplicand magnitude is rebuilt from the latched raw operand
  assign mag_b    = sb_q ? -op_b_q : op_b_q;

  mdu_iter #(.XLEN(XLEN)) u_iter (
    .is_div_i (is_div(f3_q)),
    .acc_i    (acc_q),
    .opnd_i   (mag_b),
    .acc_o    (acc_d)
  );

  always_comb begin
    prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo      = acc_q[XLEN-1:0];
    rem      = acc_q[2*XLEN-1:XLEN];
    if (!is_div(f3_q)) begin
      result_d = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end else if (is_rem(f3_q)) begin
      // Remainder follows the dividend's sign
      result_d = sa_q ? -rem : rem;
    end else begin
      result_d = (sa_q ^ sb_q) ? -quo : quo;
    end
    if (is_special(f3_q, op_a_q, op_b_q)) begin
      result_d = special_val(f3_q, op_a_q, op_b_q);
    end
  end

`ifdef MDU_FAST_SPECIAL_EN
  logic            fast_hit;
  logic [XLEN-1:0] fast_val;
  assign fast_hit = is_special(bus.funct3, bus.op_a, bus.op_b);
  assign fast_val = special_val(bus.funct3, bus.op_a, bus.op_b);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      f3_q        <= F3_MUL;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            f3_q       <= funct3_e'(bus.funct3);
            op_a_q     <= bus.op_a;
            op_b_q     <= bus.op_b;
            sa_q       <= sa_in;
            sb_q       <= sb_in;
            acc_q      <= {{XLEN{1'b0}}, mag_a_in};
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
`ifdef MDU_FAST_SPECIAL_EN
            if (fast_hit) begin
              result_q    <= fast_val;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              state_q     <= ST_CALC;
            end
`else
            state_q    <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_END) begin
            state_q <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          result_q    <= result_d;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule : mdu_seq
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu_seq
//  Purpose  : Self-checking bench for mdu_seq (XLEN=32). Directed operations
//             with literal expected values; a compare process checks every
//             presented result against an arithmetic reference model and
//             that out_valid stays low when no result is due. Latency is
//             counted with the accepting edge as clock 1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_seq;

  localparam int XLEN      = 32;
  localparam int LAT_LIMIT = 100;

  logic clk;
  logic reset_n;
  logic flush;

  mdu_seq_if #(.XLEN(XLEN)) bus ();

  mdu_seq #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  logic        exp_active = 1'b0;
  logic [31:0] exp_result = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Reference model straight from the RISC-V M-extension definitions
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f3)
      3'd0: r = sa * sb;
      3'd1: r = (sa * sb) >>> 32;
      3'd2: r = (sa * ub) >>> 32;
      3'd3: r = (ua * ub) >> 32;
      3'd4: r = (b == 0) ? -1 : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? sa : sa / sb;
      3'd5: r = (b == 0) ? -1 : ua / ub;
      3'd6: r = (b == 0) ? sa : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 0 : sa % sb;
      default: r = (b == 0) ? ua : ua % ub;
    endcase
    return r[31:0];
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef MDU_FAST_SPECIAL_EN
    if (f3[2] && (b == 0)) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (!f3[2] && (a == 0 || b == 0)) return 1;
`endif
    return XLEN + 2;
  endfunction

  // Compare process: presented results must match the model; with nothing
  // outstanding, out_valid must be low.
  always @(negedge clk) begin
    if (reset_n) begin
      if (exp_active) begin
        if (bus.out_valid) chk("cmp_result", 64'(bus.result), 64'(exp_result));
      end else begin
        chk("cmp_no_valid", 64'(bus.out_valid), 64'd0);
      end
    end
  end

  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.funct3   = f3;
    bus.op_a     = a;
    bus.op_b     = b;
    exp_result   = model(f3, a, b);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    exp_active   = 1'b1;
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit, input string nm, input int hold);
    int lat;
    start_op(f3, a, b);
    lat = 1;
    while (!bus.out_valid && lat < LAT_LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'(exp_lat(f3, a, b)));
    chk(nm, 64'(bus.result), 64'(lit));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({nm, "_bp_valid"}, 64'(bus.out_valid), 64'd1);
      chk({nm, "_bp_in_ready"}, 64'(bus.in_ready), 64'd0);
      chk({nm, "_bp_result"}, 64'(bus.result), 64'(lit));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_active = 1'b0;
    chk({nm, "_rel_in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({nm, "_rel_valid"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    clk           = 1'b0;
    reset_n       = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.funct3    = 3'd0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3",    0);
    run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulh_min",    0);
    run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1",   0);
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max",   0);
    run_op(3'd0, 32'd0,          32'd5,         32'd0,         "mul_zero",    0);
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div_m7_2",    0);
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem_m7_2",    0);
    run_op(3'd5, 32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF, "divu_max_2",  0);
    run_op(3'd7, 32'd100,        32'd7,         32'd2,         "remu_100_7",  0);
    run_op(3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, "div_by0",     0);
    run_op(3'd6, 32'd5,          32'd0,         32'd5,         "rem_by0",     0);
    run_op(3'd5, 32'd9,          32'd0,         32'hFFFF_FFFF, "divu_by0",    0);
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf",     0);
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "rem_ovf",     0);

    // Back-pressure: result held for 5 clocks in DONE
    bus.out_ready = 1'b0;
    run_op(3'd1, 32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, "bp_mulh",     5);

    // Flush during CALC iteration 10: op discarded
    start_op(3'd5, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush      = 1'b0;
    exp_active = 1'b0;
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (40) @(negedge clk);

    // flush together with in_valid in IDLE must not accept
    @(negedge clk);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.funct3   = 3'd5;
    bus.op_a     = 32'd50;
    bus.op_b     = 32'd5;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_noacc_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (40) @(negedge clk);

    run_op(3'd5, 32'd100, 32'd7, 32'd14, "divu_100_7", 0);

    // Asynchronous reset mid-CALC
    start_op(3'd0, 32'd123, 32'd456);
    repeat (5) @(posedge clk);
    #3;
    reset_n    = 1'b0;
    exp_active = 1'b0;
    #1;
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_result", 64'(bus.result), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op(3'd0, 32'd123, 32'd456, 32'd56088, "mul_after_rst", 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule : tb_mdu_seq
`default_nettype wire
